// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shift register with a valid/ready load port and
// first/last frame strobes; reloads on the last bit for gapless word streams.
module piso_shifter #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             accept;

  assign at_last    = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || (at_last && shift_en);
  assign accept     = load_valid && load_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // Covers both the idle load and the zero-gap reload on the last bit.
      state <= SHIFT;
      shreg <= load_data;
      cnt   <= '0;
    end else if (state == SHIFT && shift_en) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
        else           shreg <= {1'b0, shreg[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Serial outputs depend only on registers, never on the load/enable inputs.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    if (state == SHIFT) begin
      sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      sout_valid = 1'b1;
      first_bit  = (cnt == '0);
      last_bit   = (cnt == LAST);
    end
  end

  assign busy = sout_valid;

endmodule
